// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI SCLK controller:
//   - state_e       : controller state enumeration (IDLE, SETUP, RUN, HOLD)
//   - DivWDefault   : default width of the half-period divide value
//   - NbWDefault    : default width of the bit-count value
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int unsigned DivWDefault = 8;
  localparam int unsigned NbWDefault  = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StRun   = 2'd2,
    StHold  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_half_period_cnt.sv
// -----------------------------------------------------------------------------
// spi_half_period_cnt
// Restartable programmable half-period counter. While enabled it counts
// 0..limit and raises tick for the cycle in which the count equals limit; the
// count restarts at 0 on the following cycle. Deasserting enable (or asserting
// rst) clears the count, so the next enabled cycle starts a fresh half period.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (also used as a restart)
//   enable  in   count enable
//   limit   in   DIV_W  terminal count (half period minus one)
//   tick    out  high while enabled and count == limit
// -----------------------------------------------------------------------------
module spi_half_period_cnt
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] limit,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == limit);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == limit) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_ctrl.sv
// -----------------------------------------------------------------------------
// spi_sclk_ctrl
// SPI master clock controller. On an accepted request it latches the divide,
// bit count, CPOL and CPHA, waits one half period (SETUP), produces 2N SCLK
// toggles spaced one half period apart (first toggle at the end of SETUP),
// idles SCLK at CPOL for one more half period (HOLD), then pulses o_done.
// o_sample_en / o_shift_en are registered pulses aligned with the SCLK edge on
// which data is sampled / shifted.
//
// Optional feature: define SPI_SCLK_CTRL_ABORT_EN to add i_abort. An abort in
// SETUP, RUN or HOLD forces SCLK to CPOL on the next cycle and (re)starts a
// full HOLD half period, after which o_done is pulsed.
//
// Ports:
//   i_clk_sys    in   system clock
//   i_rst        in   synchronous active-high reset
//   i_start      in   transfer request (sampled only in IDLE)
//   i_div        in   DIV_W  half period minus one, in i_clk_sys cycles
//   i_nbits      in   NB_W   bits per transfer (0 = request ignored)
//   i_cpol       in   SCLK idle level
//   i_cpha       in   0: sample on leading edge, 1: sample on trailing edge
//   i_abort      in   abort request (only with SPI_SCLK_CTRL_ABORT_EN)
//   o_sclk       out  registered SPI clock
//   o_busy       out  high from the cycle after acceptance through o_done
//   o_done       out  single-cycle end-of-transfer pulse
//   o_sample_en  out  single-cycle pulse on sample edges
//   o_shift_en   out  single-cycle pulse on shift edges
// -----------------------------------------------------------------------------
module spi_sclk_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault,
  parameter int unsigned NB_W  = NbWDefault
) (
  input  logic             i_clk_sys,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_div,
  input  logic [NB_W-1:0]  i_nbits,
  input  logic             i_cpol,
  input  logic             i_cpha,
`ifdef SPI_SCLK_CTRL_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_sclk,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sample_en,
  output logic             o_shift_en
);

  // One extra bit so 2*(2^NB_W-1) edges fit without wrapping.
  localparam int unsigned EdgeW = NB_W + 1;

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [NB_W-1:0]    nbits_q;
  logic               cpol_q;
  logic               cpha_q;
  logic [EdgeW-1:0]   edge_q;     // SCLK toggles already produced
  logic               sclk_q;
  logic               busy_q;
  logic               done_q;
  logic               sample_q;
  logic               shift_q;

  logic               tick;
  logic               abort;
  logic               cnt_en;
  logic               cnt_rst;
  logic [EdgeW-1:0]   last_idx;
  logic               last_edge;
  logic               leading_edge;

`ifdef SPI_SCLK_CTRL_ABORT_EN
  assign abort = i_abort && (state_q != StIdle);
`else
  assign abort = 1'b0;
`endif

  // The counter idles at zero outside a transfer; an abort restarts it so the
  // HOLD that follows is a full half period.
  assign cnt_en  = (state_q != StIdle);
  assign cnt_rst = i_rst || abort;

  spi_half_period_cnt #(
    .DIV_W (DIV_W)
  ) u_half_period_cnt (
    .clk    (i_clk_sys),
    .rst    (cnt_rst),
    .enable (cnt_en),
    .limit  (div_q),
    .tick   (tick)
  );

  // edge_q counts toggles done so far: the toggle about to happen is leading
  // when an even number have been produced, and final when 2N-1 have.
  assign last_idx     = {nbits_q, 1'b0} - EdgeW'(1);
  assign last_edge    = (edge_q == last_idx);
  assign leading_edge = ~edge_q[0];

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // IDLE also covers the o_done cycle, so a held request restarts
          // immediately and o_busy stays high across back-to-back transfers.
          sclk_q <= i_cpol;
          busy_q <= 1'b0;
          if (i_start && (i_nbits != '0)) begin
            state_q <= StSetup;
            busy_q  <= 1'b1;
            div_q   <= i_div;
            nbits_q <= i_nbits;
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
            edge_q  <= '0;
          end
        end
        StSetup, StRun: begin
          if (abort) begin
            state_q <= StHold;
            sclk_q  <= cpol_q;
          end else if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + EdgeW'(1);
            if (leading_edge) begin
              sample_q <= ~cpha_q;
              shift_q  <= cpha_q;
            end else begin
              sample_q <= cpha_q;
              // With CPHA=0 there is nothing left to shift after the last bit.
              shift_q  <= ~cpha_q & ~last_edge;
            end
            state_q <= last_edge ? StHold : StRun;
          end
        end
        StHold: begin
          sclk_q <= cpol_q;
          if (!abort && tick) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_sclk      = sclk_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_sample_en = sample_q;
  assign o_shift_en  = shift_q;

endmodule
